airlock_scheduler: RTL and testbench

//  Owns the single airlock chamber and shares it between an arriving ship (arrive_req)
//  and a departing crew member (depart_req). Grants one requester at a time and sequences

---
 rtl/airlock_scheduler_pkg.sv | 30 +++
 rtl/airlock_scheduler_if.sv | 27 ++
 rtl/airlock_scheduler_timer.sv | 44 ++++
 rtl/airlock_scheduler.sv | 129 ++++++++++++
 tb/tb_airlock_scheduler.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/airlock_scheduler_pkg.sv
// Shared types and display constants for the airlock scheduler.
package airlock_scheduler_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StDock,
        StWaitEvac,
        StEvac,
        StWaitPress,
        StPress,
        StFinish
    } state_t;

    typedef enum logic [1:0] {
        DirNone,
        DirArr,
        DirDep
    } dir_t;

    // Active-low segment patterns, bit order gfedcba.
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_P     = 7'b0001100;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic logic is_timed(state_t s);
        return (s == StDock) || (s == StEvac) || (s == StPress);
    endfunction

endpackage

// File: rtl/airlock_scheduler_if.sv
// Sensor/button inputs and grant/door/display outputs of the airlock scheduler.
interface airlock_scheduler_if;

    logic       arrive_req;
    logic       depart_req;
    logic       inner_open;
    logic       outer_open;
    logic       evac_btn;
    logic       press_btn;
    logic       arrive_grant;
    logic       depart_grant;
    logic       inner_en;
    logic       outer_en;
    logic       fault;
    logic [6:0] display;

    modport master (
        output arrive_req, depart_req, inner_open, outer_open, evac_btn, press_btn,
        input  arrive_grant, depart_grant, inner_en, outer_en, fault, display
    );

    modport slave (
        input  arrive_req, depart_req, inner_open, outer_open, evac_btn, press_btn,
        output arrive_grant, depart_grant, inner_en, outer_en, fault, display
    );

endinterface

// File: rtl/airlock_scheduler_timer.sv
// Phase timer: prescaler of CLKS_PER_SEC cycles feeding a saturating 4-bit seconds count.
module airlock_scheduler_timer #(
    parameter int unsigned CLKS_PER_SEC = 50_000_000
) (
    input  logic       clock,
    input  logic       rst,
    input  logic       clear,
    output logic [3:0] sec
);

    localparam int unsigned PW = (CLKS_PER_SEC > 1) ? $clog2(CLKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLKS_PER_SEC - 1);

    logic [PW-1:0] r_presc, w_presc_base, w_presc_next;
    logic [3:0]    r_sec, w_sec_base, w_sec_next;

    // The clearing edge already counts as the first cycle of the phase, so a phase of
    // N seconds reaches sec == N after exactly N*CLKS_PER_SEC cycles in the state.
    always_comb begin
        w_presc_base = clear ? '0 : r_presc;
        w_sec_base   = clear ? 4'd0 : r_sec;
        w_presc_next = w_presc_base + PW'(1);
        w_sec_next   = w_sec_base;
        if (w_presc_base == PRESC_MAX) begin
            w_presc_next = '0;
            if (w_sec_base != 4'hf) begin
                w_sec_next = w_sec_base + 4'd1;
            end
        end
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            r_presc <= '0;
            r_sec   <= 4'd0;
        end else begin
            r_presc <= w_presc_next;
            r_sec   <= w_sec_next;
        end
    end

    assign sec = r_sec;

endmodule

// File: rtl/airlock_scheduler.sv
// Airlock chamber arbiter: grants arrival or departure and sequences dock/evac/pressurize.
module airlock_scheduler
    import airlock_scheduler_pkg::*;
#(
    parameter int unsigned CLKS_PER_SEC = 50_000_000,
    parameter int unsigned ARRIVE_SEC   = 5,
    parameter int unsigned EVAC_SEC     = 7,
    parameter int unsigned PRESS_SEC    = 8
) (
    input logic                clock,
    input logic                rst,
    airlock_scheduler_if.slave bus
);

    state_t     r_state, w_state;
    dir_t       r_dir, w_dir;
    logic       r_last_dep, w_last_dep;
    logic       r_fault, w_fault;
    logic       w_clear;
    logic       w_closed;
    logic       w_own_req;
    logic [3:0] w_sec;

    airlock_scheduler_timer #(
        .CLKS_PER_SEC(CLKS_PER_SEC)
    ) u_timer (
        .clock(clock),
        .rst  (rst),
        .clear(w_clear),
        .sec  (w_sec)
    );

    assign w_closed  = !bus.inner_open && !bus.outer_open;
    assign w_own_req = (r_dir == DirArr) ? bus.arrive_req : bus.depart_req;
    assign w_clear   = is_timed(w_state) && (w_state != r_state);

    always_comb begin
        w_state    = r_state;
        w_dir      = r_dir;
        w_last_dep = r_last_dep;
        w_fault    = 1'b0;
        case (r_state)
            StIdle: begin
                // On a tie the side not served last wins.
                if (bus.arrive_req && (!bus.depart_req || r_last_dep)) begin
                    w_state    = StDock;
                    w_dir      = DirArr;
                    w_last_dep = 1'b0;
                end else if (bus.depart_req) begin
                    w_state    = StWaitEvac;
                    w_dir      = DirDep;
                    w_last_dep = 1'b1;
                end
            end
            StDock: begin
                if (!bus.arrive_req) begin
                    w_state = StIdle;
                    w_dir   = DirNone;
                end else if (w_sec == 4'(ARRIVE_SEC)) begin
                    w_state = StWaitEvac;
                end
            end
            StWaitEvac: begin
                if (bus.evac_btn && w_closed) w_state = StEvac;
            end
            StEvac: begin
                if (!w_closed) begin
                    w_state = StWaitEvac;
                    w_fault = 1'b1;
                end else if (w_sec == 4'(EVAC_SEC)) begin
                    w_state = StWaitPress;
                end
            end
            StWaitPress: begin
                if (bus.press_btn && w_closed) w_state = StPress;
            end
            StPress: begin
                if (!w_closed) begin
                    w_state = StWaitPress;
                    w_fault = 1'b1;
                end else if (w_sec == 4'(PRESS_SEC)) begin
                    w_state = StFinish;
                end
            end
            StFinish: begin
                if (!w_own_req && w_closed) begin
                    w_state = StIdle;
                    w_dir   = DirNone;
                end
            end
            default: begin
                w_state = StIdle;
                w_dir   = DirNone;
            end
        endcase
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            r_state    <= StIdle;
            r_dir      <= DirNone;
            r_last_dep <= 1'b1;
            r_fault    <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_dir      <= w_dir;
            r_last_dep <= w_last_dep;
            r_fault    <= w_fault;
        end
    end

    assign bus.arrive_grant = (r_state != StIdle) && (r_dir == DirArr);
    assign bus.depart_grant = (r_state != StIdle) && (r_dir == DirDep);
    assign bus.inner_en     = ((r_state == StWaitEvac) && (r_dir == DirDep)) ||
                              ((r_state == StFinish) && (r_dir == DirArr));
    assign bus.outer_en     = (r_state == StWaitPress);
    assign bus.fault        = r_fault;

    always_comb begin
        bus.display = SEG_BLANK;
        case (r_state)
            StDock:  bus.display = SEG_A;
            StEvac:  bus.display = SEG_E;
            StPress: bus.display = SEG_P;
            default: bus.display = SEG_BLANK;
        endcase
    end

endmodule

// File: tb/tb_airlock_scheduler.sv
// Bench for airlock_scheduler: vector table, corner-case sequences, random vs reference model.
module tb_airlock_scheduler;

    localparam int unsigned CPS   = 4;
    localparam int unsigned A_SEC = 5;
    localparam int unsigned E_SEC = 7;
    localparam int unsigned P_SEC = 8;

    localparam logic [6:0] SA = 7'b0001000;
    localparam logic [6:0] SE = 7'b0000110;
    localparam logic [6:0] SP = 7'b0001100;
    localparam logic [6:0] SB = 7'b1111111;

    localparam int PH_IDLE = 0, PH_DOCK = 1, PH_WEVAC = 2, PH_EVAC = 3;
    localparam int PH_WPRESS = 4, PH_PRESS = 5, PH_FINISH = 6;
    localparam int OWN_NONE = 0, OWN_ARR = 1, OWN_DEP = 2;

    typedef struct {
        logic        a, d, inr, outr, ev, pr;
        int unsigned n;
        logic [11:0] exp;
    } vec_t;

    logic clock = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_err    = 0;

    always #5 clock = ~clock;

    airlock_scheduler_if bus ();

    airlock_scheduler #(
        .CLKS_PER_SEC(CPS),
        .ARRIVE_SEC  (A_SEC),
        .EVAC_SEC    (E_SEC),
        .PRESS_SEC   (P_SEC)
    ) dut (
        .clock(clock),
        .rst  (rst),
        .bus  (bus)
    );

    logic [11:0] obs;
    assign obs = {bus.arrive_grant, bus.depart_grant, bus.inner_en, bus.outer_en, bus.fault,
                  bus.display};

    // Reference model: phase, owner and a countdown of cycles remaining in a timed phase.
    int m_phase, m_owner, m_left;
    bit m_last_dep, m_fault;

    function automatic logic [11:0] ev(logic ga, logic gd, logic ie, logic oe, logic f,
                                       logic [6:0] disp);
        return {ga, gd, ie, oe, f, disp};
    endfunction

    function automatic vec_t mk(logic a, logic d, logic inr, logic outr, logic e, logic p,
                                int unsigned n, logic [11:0] exp);
        vec_t v;
        v.a = a; v.d = d; v.inr = inr; v.outr = outr; v.ev = e; v.pr = p;
        v.n = n; v.exp = exp;
        return v;
    endfunction

    task automatic check(input string name, input logic [11:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %b want %b at %0t", name, obs, exp, $time);
        end
    endtask

    task automatic set_in(input logic a, input logic d, input logic inr, input logic outr,
                          input logic e, input logic p);
        bus.arrive_req = a;
        bus.depart_req = d;
        bus.inner_open = inr;
        bus.outer_open = outr;
        bus.evac_btn   = e;
        bus.press_btn  = p;
    endtask

    task automatic step(input int unsigned n);
        repeat (n) @(negedge clock);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_in(0, 0, 0, 0, 0, 0);
        step(2);
        rst = 1'b0;
    endtask

    task automatic model_reset();
        m_phase    = PH_IDLE;
        m_owner    = OWN_NONE;
        m_left     = 0;
        m_last_dep = 1'b1;
        m_fault    = 1'b0;
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        bit closed, own_req;
        closed  = !bus.inner_open && !bus.outer_open;
        own_req = (m_owner == OWN_ARR) ? bus.arrive_req : bus.depart_req;
        m_fault = 1'b0;
        case (m_phase)
            PH_IDLE: begin
                if (bus.arrive_req && (!bus.depart_req || m_last_dep)) begin
                    m_phase = PH_DOCK; m_owner = OWN_ARR; m_last_dep = 1'b0;
                    m_left = A_SEC * CPS;
                end else if (bus.depart_req) begin
                    m_phase = PH_WEVAC; m_owner = OWN_DEP; m_last_dep = 1'b1;
                end
            end
            PH_DOCK: begin
                if (!bus.arrive_req) begin m_phase = PH_IDLE; m_owner = OWN_NONE; end
                else if (m_left == 1) m_phase = PH_WEVAC;
                else m_left--;
            end
            PH_WEVAC: if (bus.evac_btn && closed) begin
                m_phase = PH_EVAC; m_left = E_SEC * CPS;
            end
            PH_EVAC: begin
                if (!closed) begin m_phase = PH_WEVAC; m_fault = 1'b1; end
                else if (m_left == 1) m_phase = PH_WPRESS;
                else m_left--;
            end
            PH_WPRESS: if (bus.press_btn && closed) begin
                m_phase = PH_PRESS; m_left = P_SEC * CPS;
            end
            PH_PRESS: begin
                if (!closed) begin m_phase = PH_WPRESS; m_fault = 1'b1; end
                else if (m_left == 1) m_phase = PH_FINISH;
                else m_left--;
            end
            default: if (!own_req && closed) begin m_phase = PH_IDLE; m_owner = OWN_NONE; end
        endcase
    endtask

    function automatic logic [11:0] model_exp();
        logic ga, gd, ie, oe;
        logic [6:0] disp;
        ga   = (m_phase != PH_IDLE) && (m_owner == OWN_ARR);
        gd   = (m_phase != PH_IDLE) && (m_owner == OWN_DEP);
        ie   = (m_phase == PH_WEVAC && m_owner == OWN_DEP) ||
               (m_phase == PH_FINISH && m_owner == OWN_ARR);
        oe   = (m_phase == PH_WPRESS);
        disp = (m_phase == PH_DOCK) ? SA : (m_phase == PH_EVAC) ? SE :
               (m_phase == PH_PRESS) ? SP : SB;
        return ev(ga, gd, ie, oe, m_fault, disp);
    endfunction

    vec_t tbl[22];

    initial begin
        // Arrival cycle entered through a tie, then a departure won by the alternating tie.
        tbl[0]  = mk(1, 1, 0, 0, 0, 0, 1,  ev(1, 0, 0, 0, 0, SA));
        tbl[1]  = mk(1, 1, 0, 0, 0, 0, 19, ev(1, 0, 0, 0, 0, SA));
        tbl[2]  = mk(1, 1, 0, 0, 0, 0, 1,  ev(1, 0, 0, 0, 0, SB));
        tbl[3]  = mk(1, 1, 0, 0, 1, 0, 1,  ev(1, 0, 0, 0, 0, SE));
        tbl[4]  = mk(1, 1, 0, 0, 0, 0, 27, ev(1, 0, 0, 0, 0, SE));
        tbl[5]  = mk(1, 1, 0, 0, 0, 0, 1,  ev(1, 0, 0, 1, 0, SB));
        tbl[6]  = mk(1, 1, 0, 0, 0, 1, 1,  ev(1, 0, 0, 0, 0, SP));
        tbl[7]  = mk(1, 1, 0, 0, 0, 0, 31, ev(1, 0, 0, 0, 0, SP));
        tbl[8]  = mk(1, 1, 0, 0, 0, 0, 1,  ev(1, 0, 1, 0, 0, SB));
        tbl[9]  = mk(0, 0, 0, 0, 0, 0, 1,  ev(0, 0, 0, 0, 0, SB));
        tbl[10] = mk(1, 1, 0, 0, 0, 0, 1,  ev(0, 1, 1, 0, 0, SB));
        tbl[11] = mk(1, 1, 0, 0, 0, 1, 2,  ev(0, 1, 1, 0, 0, SB));
        tbl[12] = mk(1, 1, 1, 0, 1, 1, 2,  ev(0, 1, 1, 0, 0, SB));
        tbl[13] = mk(1, 1, 0, 0, 1, 1, 1,  ev(0, 1, 0, 0, 0, SE));
        tbl[14] = mk(1, 1, 0, 0, 1, 1, 27, ev(0, 1, 0, 0, 0, SE));
        tbl[15] = mk(1, 1, 0, 0, 1, 1, 1,  ev(0, 1, 0, 1, 0, SB));
        tbl[16] = mk(1, 1, 0, 0, 1, 0, 3,  ev(0, 1, 0, 1, 0, SB));
        tbl[17] = mk(1, 1, 0, 0, 0, 1, 1,  ev(0, 1, 0, 0, 0, SP));
        tbl[18] = mk(1, 1, 0, 0, 0, 0, 31, ev(0, 1, 0, 0, 0, SP));
        tbl[19] = mk(1, 1, 0, 0, 0, 0, 1,  ev(0, 1, 0, 0, 0, SB));
        tbl[20] = mk(1, 0, 0, 1, 0, 0, 1,  ev(0, 1, 0, 0, 0, SB));
        tbl[21] = mk(0, 0, 0, 0, 0, 0, 1,  ev(0, 0, 0, 0, 0, SB));

        rst = 1'b1;
        set_in(0, 0, 0, 0, 0, 0);
        #1;
        check("reset_held", ev(0, 0, 0, 0, 0, SB));
        @(negedge clock);
        rst = 1'b0;
        check("reset_idle", ev(0, 0, 0, 0, 0, SB));

        for (int i = 0; i < 22; i++) begin
            set_in(tbl[i].a, tbl[i].d, tbl[i].inr, tbl[i].outr, tbl[i].ev, tbl[i].pr);
            step(tbl[i].n);
            check($sformatf("vec%0d", i), tbl[i].exp);
        end

        // Door opened mid-evacuation, then a fresh full-length evacuation.
        do_reset();
        set_in(1, 0, 0, 0, 0, 0);
        step(21);
        check("fault_wait_evac", ev(1, 0, 0, 0, 0, SB));
        bus.evac_btn = 1'b1;
        step(1);
        bus.evac_btn = 1'b0;
        step(9);
        check("evac_c10", ev(1, 0, 0, 0, 0, SE));
        bus.outer_open = 1'b1;
        step(1);
        check("fault_pulse", ev(1, 0, 0, 0, 1, SB));
        bus.outer_open = 1'b0;
        step(1);
        check("fault_clear", ev(1, 0, 0, 0, 0, SB));
        bus.evac_btn = 1'b1;
        step(1);
        bus.evac_btn = 1'b0;
        step(27);
        check("evac_rerun", ev(1, 0, 0, 0, 0, SE));
        step(1);
        check("evac_rerun_done", ev(1, 0, 0, 1, 0, SB));

        // Ship leaves during docking.
        do_reset();
        set_in(1, 0, 0, 0, 0, 0);
        step(8);
        check("dock_c8", ev(1, 0, 0, 0, 0, SA));
        bus.arrive_req = 1'b0;
        step(1);
        check("dock_drop", ev(0, 0, 0, 0, 0, SB));

        // Asynchronous reset while pressurizing.
        do_reset();
        set_in(1, 0, 0, 0, 0, 0);
        step(21);
        bus.evac_btn = 1'b1;
        step(1);
        bus.evac_btn = 1'b0;
        step(28);
        check("rst_seq_wpress", ev(1, 0, 0, 1, 0, SB));
        bus.press_btn = 1'b1;
        step(1);
        bus.press_btn = 1'b0;
        step(5);
        check("rst_seq_press", ev(1, 0, 0, 0, 0, SP));
        rst = 1'b1;
        #1;
        check("rst_async", ev(0, 0, 0, 0, 0, SB));
        step(1);
        rst = 1'b0;
        step(1);
        check("rst_reaccept", ev(1, 0, 0, 0, 0, SA));

        // Randomized traffic against the reference model.
        do_reset();
        model_reset();
        for (int c = 0; c < 4000; c++) begin
            check("rand", model_exp());
            if ($urandom_range(0, 39) == 0) bus.arrive_req = ~bus.arrive_req;
            if ($urandom_range(0, 39) == 0) bus.depart_req = ~bus.depart_req;
            bus.inner_open = ($urandom_range(0, 63) == 0);
            bus.outer_open = ($urandom_range(0, 63) == 0);
            bus.evac_btn   = ($urandom_range(0, 2) == 0);
            bus.press_btn  = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 499) == 0) begin
                rst = 1'b1;
                #1;
                model_reset();
                rst = 1'b0;
            end
            model_step();
            @(negedge clock);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
